aes_iter_cipher: RTL and testbench

Iterative, parametrised AES block encryptor: one round per clock over a single shared round datapath, with an internal sequential key expansion into a round-key store. Supports AES-128, AES-192 and AES-256, selected by elaboration parameter. Sits between the plaintext source and the ciphertext sink of the crypto datapath, behind valid/ready handshakes on both sides. The stored key schedule can be reused across blocks so that a re-key is paid only when requested.

---
 rtl/aes_pkg.sv | 68 ++++++
 rtl/aes_round.sv | 35 +++
 rtl/aes_iter_cipher.sv | 145 ++++++++++++++
 tb/tb_aes_iter_cipher.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES helpers (S-box, GF(2^8) multiplies, Rcon,
// Nk/Nr helpers) and the encryptor FSM state enum.
package aes_pkg;

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_e;

  function automatic int nk_of(input int kb);
    return kb / 32;
  endfunction

  function automatic int nr_of(input int kb);
    return kb / 32 + 6;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul02(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] mul03(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 (0 maps to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Rcon[j] top byte, j = 1..10.
  function automatic logic [7:0] rcon(input int j);
    logic [7:0] c;
    c = 8'h01;
    for (int k = 2; k <= 10; k++)
      if (k <= j) c = xtime(c);
    return c;
  endfunction

endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES round. Ports: state_i, rk_i in;
// final_i skips MixColumns; state_o = round(state_i) ^ rk_i.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         final_i,
  output logic [127:0] state_o
);

  logic [7:0] sb [16];
  logic [7:0] sr [16];
  logic [7:0] mc [16];

  // Byte n sits at bits [127-8n -: 8]; column c = n/4, row = n%4.
  always_comb begin
    state_o = '0;
    for (int n = 0; n < 16; n++)
      sb[n] = sbox(state_i[127-8*n -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        mc[4*c+r] = mul02(sr[4*c+r])
                  ^ mul03(sr[4*c+(r+1)%4])
                  ^ sr[4*c+(r+2)%4]
                  ^ sr[4*c+(r+3)%4];
    for (int n = 0; n < 16; n++)
      state_o[127-8*n -: 8] =
        (final_i ? sr[n] : mc[n]) ^ rk_i[127-8*n -: 8];
  end

endmodule

// File: rtl/aes_iter_cipher.sv
// aes_iter_cipher: iterative AES-128/192/256 encryptor, one round per
// clock, with sequential key expansion into a reusable round-key store.
// Ports: clk, rst (async high); in_valid/in_ready/in_block/in_key/
// in_new_key request side; out_valid/out_ready/out_block result side;
// key_loaded flags a complete stored schedule.
module aes_iter_cipher
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        in_block,
  input  logic [KEY_BITS-1:0] in_key,
  input  logic                in_new_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        out_block,
  output logic                key_loaded
);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad
    $error("aes_iter_cipher: KEY_BITS must be 128, 192 or 256");
  end

  localparam int NK = nk_of(KEY_BITS);
  localparam int NR = nr_of(KEY_BITS);
  localparam int NW = 4 * (NR + 1);

  state_e       st_q, st_d;
  logic [127:0] blk_q, blk_d;
  logic [5:0]   wi_q, wi_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         kl_q, kl_d;
  logic         load, gen;

  logic [31:0]  w_q [NW];
  logic [5:0]   ip, io;
  logic [31:0]  t, nw;
  int           wi, wm;
  logic [127:0] rk, rnd_out;

  // Next schedule word w[wi_q] from w[wi_q-1] and w[wi_q-Nk].
  always_comb begin
    ip = wi_q - 6'd1;
    io = wi_q - 6'(NK);
    t  = w_q[ip];
    wi = int'(wi_q);
    wm = wi % NK;
    if (wm == 0)
      nw = w_q[io] ^ subword({t[23:0], t[31:24]})
         ^ {rcon(wi / NK), 24'h0};
    else if (NK == 8 && wm == 4)
      nw = w_q[io] ^ subword(t);
    else
      nw = w_q[io] ^ t;
  end

  assign rk = {w_q[{rnd_q, 2'b00}], w_q[{rnd_q, 2'b01}],
               w_q[{rnd_q, 2'b10}], w_q[{rnd_q, 2'b11}]};

  aes_round u_round (
    .state_i (blk_q),
    .rk_i    (rk),
    .final_i (rnd_q == 4'(NR)),
    .state_o (rnd_out)
  );

  always_comb begin
    st_d  = st_q;
    blk_d = blk_q;
    wi_d  = wi_q;
    rnd_d = rnd_q;
    kl_d  = kl_q;
    load  = 1'b0;
    gen   = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (in_valid) begin
          blk_d = in_block;
          rnd_d = '0;
          if (in_new_key || !kl_q) begin
            load  = 1'b1;
            kl_d  = 1'b0;
            wi_d  = 6'(NK);
            st_d  = KEYEXP;
          end else begin
            st_d  = ROUND;
          end
        end
      end
      KEYEXP: begin
        gen  = 1'b1;
        wi_d = wi_q + 6'd1;
        if (wi_q == 6'(NW - 1)) begin
          kl_d = 1'b1;
          st_d = ROUND;
        end
      end
      ROUND: begin
        blk_d = (rnd_q == 4'd0) ? (blk_q ^ rk) : rnd_out;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == 4'(NR)) st_d = DONE;
      end
      DONE: begin
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q  <= IDLE;
      blk_q <= '0;
      wi_q  <= '0;
      rnd_q <= '0;
      kl_q  <= 1'b0;
    end else begin
      st_q  <= st_d;
      blk_q <= blk_d;
      wi_q  <= wi_d;
      rnd_q <= rnd_d;
      kl_q  <= kl_d;
    end
  end

  // Round-key store carries no reset; key_loaded guards its use.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < NK; j++)
        w_q[j] <= in_key[KEY_BITS-1-32*j -: 32];
    end else if (gen) begin
      w_q[wi_q] <= nw;
    end
  end

  assign in_ready   = (st_q == IDLE);
  assign out_valid  = (st_q == DONE);
  assign out_block  = blk_q;
  assign key_loaded = kl_q;

endmodule

// File: tb/tb_aes_iter_cipher.sv
// tb_aes_iter_cipher: directed checks of AES-128/192/256 instances
// against a byte-level FIPS-197 reference model kept in the bench.
module tb_aes_iter_cipher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         iv [3];
  logic         nk [3];
  logic         om [3];
  logic         orr [3];
  logic         ir [3];
  logic         ov [3];
  logic         kl [3];
  logic [127:0] ib [3];
  logic [127:0] ob [3];
  logic [255:0] ik [3];
  logic         rnd_on, rnd_val;
  logic [127:0] expq [3][$];
  logic         pv [3];
  logic         phs [3];
  logic [127:0] pob [3];
  logic [7:0]   sb [256];
  logic [7:0]   gp, gq, gx;
  int           total, bad;

  localparam logic [255:0] K128 =
    {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 =
    {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  always_comb begin
    orr[0] = rnd_on ? rnd_val : om[0];
    orr[1] = om[1];
    orr[2] = om[2];
  end

  always @(posedge clk) begin
    #2;
    rnd_val = ($urandom_range(0, 3) != 0);
  end

  aes_iter_cipher #(.KEY_BITS(128)) u128 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_block(ib[0]), .in_key(ik[0][255:128]), .in_new_key(nk[0]),
    .out_valid(ov[0]), .out_ready(orr[0]), .out_block(ob[0]),
    .key_loaded(kl[0]));

  aes_iter_cipher #(.KEY_BITS(192)) u192 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_block(ib[1]), .in_key(ik[1][255:64]), .in_new_key(nk[1]),
    .out_valid(ov[1]), .out_ready(orr[1]), .out_block(ob[1]),
    .key_loaded(kl[1]));

  aes_iter_cipher #(.KEY_BITS(256)) u256 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_block(ib[2]), .in_key(ik[2]), .in_new_key(nk[2]),
    .out_valid(ov[2]), .out_ready(orr[2]), .out_block(ob[2]),
    .key_loaded(kl[2]));

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a,
                                    input logic [7:0] b);
    logic [7:0] r, x, y;
    r = 8'h00; x = a; y = b;
    while (y != 8'h00) begin
      if (y[0]) r = r ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return r;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] v);
    return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
  endfunction

  // Key is left-aligned in 256 bits; kb selects the variant.
  function automatic logic [127:0] model(input logic [127:0] pt,
                                         input logic [255:0] key,
                                         input int kb);
    int nkw, nr;
    logic [31:0] w [60];
    logic [31:0] tmp;
    logic [7:0] rc, cf, acc;
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] res;
    nkw = kb / 32; nr = nkw + 6; rc = 8'h01;
    for (int i = 0; i < nkw; i++) w[i] = key[255-32*i -: 32];
    for (int i = nkw; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nkw == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nkw == 8 && i % nkw == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-nkw] ^ tmp;
    end
    for (int j = 0; j < 16; j++)
      s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int j = 0; j < 16; j++)
        t[j] = sb[s[4*((j/4 + j%4) % 4) + j%4]];
      for (int c = 0; c < 4; c++)
        for (int i = 0; i < 4; i++) begin
          if (r == nr) begin
            s[4*c+i] = t[4*c+i];
          end else begin
            acc = 8'h00;
            for (int m = 0; m < 4; m++) begin
              case ((m - i + 4) % 4)
                0: cf = 8'h02;
                1: cf = 8'h03;
                default: cf = 8'h01;
              endcase
              acc = acc ^ gm(t[4*c+m], cf);
            end
            s[4*c+i] = acc;
          end
        end
      for (int j = 0; j < 16; j++)
        s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) res[127-8*j -: 8] = s[j];
    return res;
  endfunction

  // Output checker: ordering, hold-while-stalled, in_ready low in DONE.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        pv[k] = 1'b0;
        phs[k] = 1'b0;
      end else begin
        if (pv[k] && !phs[k]) begin
          chk($sformatf("hold_valid%0d", k), ov[k], 1);
          chk($sformatf("hold_block%0d", k), ob[k], pob[k]);
        end
        if (ov[k] === 1'b1) chk($sformatf("busy_ready%0d", k), ir[k], 0);
        if (ov[k] === 1'b1 && orr[k] === 1'b1) begin
          if (expq[k].size() == 0) begin
            total++; bad++;
            $display("FAIL spurious_out%0d: got %h want none", k, ob[k]);
          end else begin
            chk($sformatf("cipher%0d", k), ob[k], expq[k].pop_front());
          end
        end
        pv[k] = ov[k];
        phs[k] = ov[k] && orr[k];
        pob[k] = ob[k];
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the first DONE cycle.
  task automatic send(input int k, input logic [127:0] pt,
                      input logic [255:0] mkey, input logic [255:0] dkey,
                      input logic newk, input int lat);
    int n;
    logic [127:0] e;
    e = model(pt, mkey, 128 + 64*k);
    n = 0;
    while (ir[k] !== 1'b1 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (ir[k] !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout%0d: in_ready=%b want 1", k, ir[k]);
      return;
    end
    ib[k] = pt; ik[k] = dkey; nk[k] = newk; iv[k] = 1'b1;
    @(posedge clk);
    expq[k].push_back(e);
    #1;
    iv[k] = 1'b0;
    n = 0;
    while (ov[k] !== 1'b1 && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk($sformatf("latency%0d", k), n, lat);
  endtask

  initial begin
    logic [127:0] pt;
    int n;
    rst = 1'b1;
    rnd_on = 1'b0;
    for (int k = 0; k < 3; k++) begin
      iv[k] = 1'b0; nk[k] = 1'b0; om[k] = 1'b1;
      ib[k] = '0; ik[k] = '0;
    end
    gp = 8'h01; gq = 8'h01;
    do begin
      gp = gp ^ {gp[6:0], 1'b0} ^ (gp[7] ? 8'h1b : 8'h00);
      gq = gq ^ {gq[6:0], 1'b0};
      gq = gq ^ {gq[5:0], 2'b0};
      gq = gq ^ {gq[3:0], 4'b0};
      if (gq[7]) gq = gq ^ 8'h09;
      gx = gq ^ {gq[6:0], gq[7]} ^ {gq[5:0], gq[7:6]}
         ^ {gq[4:0], gq[7:5]} ^ {gq[3:0], gq[7:4]};
      sb[gp] = gx ^ 8'h63;
    end while (gp != 8'h01);
    sb[0] = 8'h63;

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready%0d", k), ir[k], 1);
      chk($sformatf("rst_out_valid%0d", k), ov[k], 0);
      chk($sformatf("rst_out_block%0d", k), ob[k], 0);
      chk($sformatf("rst_key_loaded%0d", k), kl[k], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    chk("model128", model(PT, K128, 128),
        128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    chk("model192", model(PT, K192, 192),
        128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    chk("model256", model(PT, K256, 256),
        128'h8ea2b7ca516745bfeafc49904b496089);

    send(0, PT, K128, K128, 1'b1, 51);
    chk("key_loaded128", kl[0], 1);
    send(0, PT, K128, ~K128, 1'b0, 11);
    send(1, PT, K192, K192, 1'b1, 59);
    chk("key_loaded192", kl[1], 1);
    send(1, 128'hffeeddccbbaa99887766554433221100, K192, ~K192, 1'b0, 13);
    send(2, PT, K256, K256, 1'b1, 67);
    chk("key_loaded256", kl[2], 1);
    send(2, 128'h0123456789abcdeffedcba9876543210, K256, ~K256, 1'b0, 15);

    om[0] = 1'b0;
    send(0, 128'h3243f6a8885a308d313198a2e0370734, K128, ~K128, 1'b0, 11);
    for (int c = 0; c < 20; c++) begin
      chk("stall_valid", ov[0], 1);
      chk("stall_ready", ir[0], 0);
      iv[0] = c[0];
      nk[0] = 1'b0;
      ib[0] = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    om[0] = 1'b1;
    @(posedge clk); #1;
    chk("release_ready", ir[0], 1);
    chk("release_valid", ov[0], 0);
    repeat (15) begin
      @(posedge clk); #1;
      chk("idle_after_release", ov[0], 0);
    end

    rnd_on = 1'b1;
    for (int b = 0; b < 8; b++) begin
      pt = {$urandom, $urandom, $urandom, $urandom};
      send(0, pt, K128, ~K128, 1'b0, 11);
    end
    n = 0;
    while (expq[0].size() != 0 && n < 500) begin
      @(posedge clk); #1; n++;
    end
    rnd_on = 1'b0;
    chk("stream_drained", expq[0].size(), 0);

    n = 0;
    while (ir[0] !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    ib[0] = PT; ik[0] = ~K128; nk[0] = 1'b0; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_reset_busy", ir[0], 0);
    rst = 1'b1;
    #1;
    chk("reset_out_valid", ov[0], 0);
    chk("reset_key_loaded", kl[0], 0);
    chk("reset_in_ready", ir[0], 1);
    chk("reset_out_block", ob[0], 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send(0, PT, K128, K128, 1'b0, 51);
    chk("reload_key_loaded", kl[0], 1);

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++)
      chk($sformatf("final_queue%0d", k), expq[k].size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
